// File: rtl/jam_cost_server_if.sv
// Lookup/load link between the assignment engine and the jam_cost_server cost table.
// master = engine/driver side, slave = cost-table responder.
interface jam_cost_server_if #(
  parameter int unsigned COST_W = 7,
  parameter int unsigned SUM_W  = 10,
  parameter int unsigned CNT_W  = 16
);
  logic              LD_VALID;
  logic              LD_READY;
  logic [COST_W-1:0] LD_DATA;
  logic              RELOAD;
  logic [2:0]        W;
  logic [2:0]        J;
  logic              REQ;
  logic [COST_W-1:0] Cost;
  logic              TABLE_RDY;
  logic              PERM_DONE;
  logic [SUM_W-1:0]  PERM_SUM;
  logic [CNT_W-1:0]  PERM_CNT;
  logic              PERM_ERR;
  logic [CNT_W-1:0]  ERR_CNT;
  logic [SUM_W-1:0]  GOLD_MIN;
  logic [CNT_W-1:0]  GOLD_MATCH;

  modport master (
    output LD_VALID, LD_DATA, RELOAD, W, J, REQ,
    input  LD_READY, Cost, TABLE_RDY, PERM_DONE, PERM_SUM, PERM_CNT,
           PERM_ERR, ERR_CNT, GOLD_MIN, GOLD_MATCH
  );

  modport slave (
    input  LD_VALID, LD_DATA, RELOAD, W, J, REQ,
    output LD_READY, Cost, TABLE_RDY, PERM_DONE, PERM_SUM, PERM_CNT,
           PERM_ERR, ERR_CNT, GOLD_MIN, GOLD_MATCH
  );
endinterface

// File: rtl/jam_cost_server.sv
// 8x8 cost-table responder with zero-latency (W,J) lookup and a permutation-walk monitor.
// Optional: define GOLD_MIN_EN to build the minimum-sum tracker (GOLD_MIN / GOLD_MATCH).
module jam_cost_server #(
  parameter int unsigned COST_W = 7,
  parameter int unsigned SUM_W  = 10,
  parameter int unsigned CNT_W  = 16
) (
  input logic              CLK,
  input logic              RST_N,
  jam_cost_server_if.slave bus
);

  localparam int unsigned DEPTH = 64;
  localparam int unsigned IDX_W = 6;

  typedef enum logic {ST_LOAD, ST_SERVE} state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx, idx_nx;
  logic              ld_fire;
  logic              ld_ready, table_rdy;
  logic [COST_W-1:0] cost_tab [DEPTH];
  logic [COST_W-1:0] cost_c;

  logic [2:0]        exp_w;
  logic [7:0]        used;
  logic [SUM_W-1:0]  acc;
  logic              req_act, req_legal;
  logic [SUM_W-1:0]  sum_nx;

  logic              perm_done, perm_err;
  logic [SUM_W-1:0]  perm_sum;
  logic [CNT_W-1:0]  perm_cnt, err_cnt;
  logic [SUM_W-1:0]  gold_min;
  logic [CNT_W-1:0]  gold_match;

  // Next-state: RELOAD always returns to LOAD with the index rewound
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    ld_fire  = 1'b0;
    if (bus.RELOAD) begin
      state_nx = ST_LOAD;
      idx_nx   = '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (bus.LD_VALID) begin
            ld_fire = 1'b1;
            idx_nx  = idx + IDX_W'(1);
            if (idx == IDX_W'(DEPTH - 1)) state_nx = ST_SERVE;
          end
        end
        ST_SERVE: state_nx = ST_SERVE;
        default:  state_nx = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_LOAD;
      idx       <= '0;
      ld_ready  <= 1'b1;
      table_rdy <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      ld_ready  <= (state_nx == ST_LOAD);
      table_rdy <= (state_nx == ST_SERVE);
    end
  end

  // Table storage has no reset; contents are only meaningful once TABLE_RDY is high
  always_ff @(posedge CLK) begin
    if (ld_fire) cost_tab[idx] <= bus.LD_DATA;
  end

  assign cost_c    = (state == ST_SERVE) ? cost_tab[{bus.W, bus.J}] : '0;
  assign req_act   = bus.REQ && (state == ST_SERVE);
  assign req_legal = (bus.W == exp_w) && !used[bus.J];
  assign sum_nx    = acc + SUM_W'(cost_c);

  // Walk monitor: any illegal step drops the partial walk and waits for a fresh W=0
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      exp_w     <= '0;
      used      <= '0;
      acc       <= '0;
      perm_done <= 1'b0;
      perm_sum  <= '0;
      perm_cnt  <= '0;
      perm_err  <= 1'b0;
      err_cnt   <= '0;
    end else if (bus.RELOAD) begin
      exp_w     <= '0;
      used      <= '0;
      acc       <= '0;
      perm_done <= 1'b0;
      perm_sum  <= '0;
      perm_cnt  <= '0;
      perm_err  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      perm_done <= 1'b0;
      if (req_act) begin
        if (!req_legal) begin
          perm_err <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
          exp_w <= '0;
          used  <= '0;
          acc   <= '0;
        end else if (bus.W != 3'd7) begin
          used[bus.J] <= 1'b1;
          acc         <= sum_nx;
          exp_w       <= exp_w + 3'd1;
        end else begin
          perm_sum  <= sum_nx;
          perm_done <= 1'b1;
          if (perm_cnt != '1) perm_cnt <= perm_cnt + CNT_W'(1);
          exp_w <= '0;
          used  <= '0;
          acc   <= '0;
        end
      end
    end
  end

`ifdef GOLD_MIN_EN
  logic perm_fin;
  assign perm_fin = req_act && req_legal && (bus.W == 3'd7);

  // Track the smallest completed sum and how many completions hit it
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      gold_min   <= '1;
      gold_match <= '0;
    end else if (bus.RELOAD) begin
      gold_min   <= '1;
      gold_match <= '0;
    end else if (perm_fin) begin
      if (sum_nx < gold_min) begin
        gold_min   <= sum_nx;
        gold_match <= CNT_W'(1);
      end else if ((sum_nx == gold_min) && (gold_match != '1)) begin
        gold_match <= gold_match + CNT_W'(1);
      end
    end
  end
`else
  assign gold_min   = '1;
  assign gold_match = '0;
`endif

  assign bus.LD_READY   = ld_ready;
  assign bus.TABLE_RDY  = table_rdy;
  assign bus.Cost       = cost_c;
  assign bus.PERM_DONE  = perm_done;
  assign bus.PERM_SUM   = perm_sum;
  assign bus.PERM_CNT   = perm_cnt;
  assign bus.PERM_ERR   = perm_err;
  assign bus.ERR_CNT    = err_cnt;
  assign bus.GOLD_MIN   = gold_min;
  assign bus.GOLD_MATCH = gold_match;

endmodule

// File: tb/tb_jam_cost_server.sv
// Scoreboard bench for jam_cost_server: behavioural walk model, completions queued and
// compared when PERM_DONE fires. Honours GOLD_MIN_EN like the design.
module tb_jam_cost_server;

  localparam int unsigned COST_W = 7;
  localparam int unsigned SUM_W  = 10;
  localparam int unsigned CNT_W  = 16;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] gmin;
    logic [CNT_W-1:0] gmatch;
    logic [CNT_W-1:0] cnt;
  } done_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  jam_cost_server_if #(.COST_W(COST_W), .SUM_W(SUM_W), .CNT_W(CNT_W)) bus ();
  jam_cost_server #(.COST_W(COST_W), .SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [COST_W-1:0] tab [64];
  logic              m_serve, m_done, m_err;
  logic [2:0]        m_exp_w;
  logic [7:0]        m_used;
  logic [SUM_W-1:0]  m_acc, m_sum, m_gmin;
  logic [CNT_W-1:0]  m_cnt, m_err_cnt, m_gmatch;
  done_t             sb [$];
  logic [7:0][2:0]   ident, js;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_serve = 1'b0; m_done = 1'b0; m_err = 1'b0;
    m_exp_w = '0; m_used = '0; m_acc = '0; m_sum = '0;
    m_cnt = '0; m_err_cnt = '0; m_gmin = '1; m_gmatch = '0;
  endtask

  task automatic model_req(input logic [2:0] w, input logic [2:0] j, input logic [COST_W-1:0] c);
    logic [SUM_W-1:0] s;
    s = m_acc + SUM_W'(c);
    if (w != m_exp_w || m_used[j]) begin
      m_err = 1'b1;
      if (m_err_cnt != '1) m_err_cnt = m_err_cnt + CNT_W'(1);
      m_exp_w = '0; m_used = '0; m_acc = '0;
    end else if (w != 3'd7) begin
      m_used[j] = 1'b1; m_acc = s; m_exp_w = m_exp_w + 3'd1;
    end else begin
      m_sum = s; m_done = 1'b1;
      if (m_cnt != '1) m_cnt = m_cnt + CNT_W'(1);
`ifdef GOLD_MIN_EN
      if (s < m_gmin) begin
        m_gmin = s; m_gmatch = CNT_W'(1);
      end else if (s == m_gmin && m_gmatch != '1) begin
        m_gmatch = m_gmatch + CNT_W'(1);
      end
`endif
      sb.push_back('{sum: s, gmin: m_gmin, gmatch: m_gmatch, cnt: m_cnt});
      m_exp_w = '0; m_used = '0; m_acc = '0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_ld_ready"},  32'(bus.LD_READY),   32'(!m_serve));
    check({tag, "_table_rdy"}, 32'(bus.TABLE_RDY),  32'(m_serve));
    check({tag, "_done"},      32'(bus.PERM_DONE),  32'(m_done));
    check({tag, "_sum"},       32'(bus.PERM_SUM),   32'(m_sum));
    check({tag, "_cnt"},       32'(bus.PERM_CNT),   32'(m_cnt));
    check({tag, "_err"},       32'(bus.PERM_ERR),   32'(m_err));
    check({tag, "_err_cnt"},   32'(bus.ERR_CNT),    32'(m_err_cnt));
    check({tag, "_gold_min"},  32'(bus.GOLD_MIN),   32'(m_gmin));
    check({tag, "_gold_match"},32'(bus.GOLD_MATCH), 32'(m_gmatch));
  endtask

  // One cycle of lookup/request traffic; Cost is checked combinationally before the edge
  task automatic cyc(input logic [2:0] w, input logic [2:0] j, input logic req, input logic rl);
    logic [COST_W-1:0] c;
    bus.W = w; bus.J = j; bus.REQ = req; bus.RELOAD = rl; bus.LD_VALID = 1'b0;
    #1;
    c = m_serve ? tab[{w, j}] : '0;
    check("cost", 32'(bus.Cost), 32'(c));
    m_done = 1'b0;
    if (rl) model_reset();
    else if (req && m_serve) model_req(w, j, c);
    @(posedge CLK); #1;
    bus.REQ = 1'b0; bus.RELOAD = 1'b0;
  endtask

  task automatic load(input int n, input bit gaps);
    int k = 0;
    int guard = 0;
    bus.REQ = 1'b0; bus.RELOAD = 1'b0;
    while (k < n && guard < 1000) begin
      bus.LD_VALID = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.LD_DATA  = tab[k];
      #1;
      if (bus.LD_VALID && bus.LD_READY) k++;
      @(posedge CLK); #1;
      guard++;
    end
    bus.LD_VALID = 1'b0;
    check("load_accepts", 32'(k), 32'(n));
    m_done = 1'b0;
    if (n == 64) m_serve = 1'b1;
  endtask

  task automatic walk(input logic [7:0][2:0] p, input int upto);
    for (int w = 0; w < upto; w++) cyc(3'(w), p[w], 1'b1, 1'b0);
  endtask

  task automatic rand_perm(output logic [7:0][2:0] p);
    int t;
    logic [2:0] tmp;
    for (int i = 0; i < 8; i++) p[i] = 3'(i);
    for (int i = 7; i > 0; i--) begin
      t = int'($urandom_range(0, i));
      tmp = p[i]; p[i] = p[t]; p[t] = tmp;
    end
  endtask

  // Scoreboard consumer: every PERM_DONE pulse must match a queued completion
  always @(negedge CLK) begin
    done_t e;
    if (RST_N && bus.PERM_DONE === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_sum",        32'(bus.PERM_SUM),   32'(e.sum));
        check("sb_cnt",        32'(bus.PERM_CNT),   32'(e.cnt));
        check("sb_gold_min",   32'(bus.GOLD_MIN),   32'(e.gmin));
        check("sb_gold_match", 32'(bus.GOLD_MATCH), 32'(e.gmatch));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.LD_VALID = 1'b0; bus.LD_DATA = '0; bus.RELOAD = 1'b0;
    bus.W = '0; bus.J = '0; bus.REQ = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) ident[i] = 3'(i);
    repeat (3) @(posedge CLK);
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK); #1;
    check_outputs("rst");
    check("rst_cost", 32'(bus.Cost), 32'd0);

    // Ramp table, continuous valid
    for (int i = 0; i < 64; i++) tab[i] = COST_W'(i);
    load(64, 1'b0);
    check_outputs("load1");
    bus.W = 3'd3; bus.J = 3'd5; #1;
    check("cost_w3j5", 32'(bus.Cost), 32'd29);
    @(posedge CLK); #1;

    walk(ident, 8);
    check_outputs("ident1");
    check("ident1_sum252", 32'(bus.PERM_SUM), 32'd252);

    // Repeated job, then a clean walk on a fresh load
    cyc(3'd0, 3'd0, 1'b0, 1'b1);
    load(64, 1'b0);
    cyc(3'd0, 3'd2, 1'b1, 1'b0);
    cyc(3'd1, 3'd2, 1'b1, 1'b0);
    check_outputs("dupj");
    check("dupj_err_cnt1", 32'(bus.ERR_CNT), 32'd1);
    walk(ident, 8);
    check_outputs("after_dupj");
    check("after_dupj_cnt1", 32'(bus.PERM_CNT), 32'd1);

    // Skipped worker resyncs
    cyc(3'd0, 3'd0, 1'b1, 1'b0);
    cyc(3'd2, 3'd1, 1'b1, 1'b0);
    check_outputs("skipw");
    walk(ident, 8);
    check_outputs("after_skipw");

    // Partial load, reload mid-load, gapped full load of random data
    cyc(3'd0, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) tab[i] = COST_W'($urandom_range(0, 127));
    load(20, 1'b1);
    cyc(3'd0, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) tab[i] = COST_W'($urandom_range(0, 127));
    load(64, 1'b1);
    check_outputs("load_gaps");
    for (int i = 0; i < 64; i++) cyc(3'(i >> 3), 3'(i & 7), 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      rand_perm(js);
      walk(js, 8);
    end
    check_outputs("rand_walks");

    // RELOAD at W=4 mid-walk, then REQ while loading
    rand_perm(js);
    walk(js, 4);
    cyc(3'd4, js[4], 1'b1, 1'b1);
    check_outputs("reload_mid");
    cyc(3'd0, 3'd0, 1'b1, 1'b0);
    cyc(3'd5, 3'd5, 1'b1, 1'b0);
    check_outputs("req_in_load");

    // Gold-min: three equal walks back to back, then a cheaper table
    for (int i = 0; i < 64; i++) tab[i] = COST_W'(5);
    load(64, 1'b0);
    walk(ident, 8);
    walk(ident, 8);
    walk(ident, 8);
    check_outputs("gold3");
`ifdef GOLD_MIN_EN
    check("gold3_min",   32'(bus.GOLD_MIN),   32'd40);
    check("gold3_match", 32'(bus.GOLD_MATCH), 32'd3);
`else
    check("gold3_min",   32'(bus.GOLD_MIN),   32'd1023);
    check("gold3_match", 32'(bus.GOLD_MATCH), 32'd0);
`endif
    cyc(3'd0, 3'd0, 1'b0, 1'b1);
    tab[0] = COST_W'(4);
    load(64, 1'b0);
    walk(ident, 8);
    check_outputs("gold39");
`ifdef GOLD_MIN_EN
    check("gold39_min",   32'(bus.GOLD_MIN),   32'd39);
    check("gold39_match", 32'(bus.GOLD_MATCH), 32'd1);
`else
    check("gold39_min",   32'(bus.GOLD_MIN),   32'd1023);
    check("gold39_match", 32'(bus.GOLD_MATCH), 32'd0);
`endif

    @(posedge CLK); #1;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
